// File: rtl/weight_loader.sv
// Weight-tile loader for an N x N weight-stationary systolic array: buffers N rows,
// then streams them down the psum path with diagonal column skew and per-column capture.
module weight_loader #(
  parameter int N          = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      w_valid,
  input  logic [N*DATA_WIDTH-1:0]   w_data,
  output logic                      w_ready,
  output logic [N*ACC_WIDTH-1:0]    psum_top,
  output logic                      en_weight_pass,
  output logic [N-1:0]              en_weight_capture,
  output logic                      busy,
  output logic                      done
);

  localparam int RW = $clog2(N);
  localparam int SW = $clog2(2*N-1);
  localparam logic [RW-1:0] ROW_LAST = RW'(N-1);
  localparam logic [SW-1:0] S_LAST   = SW'(2*N-2);

  typedef enum logic [1:0] {IDLE, FILL, STREAM, DONE} state_t;

  state_t                  state, state_nx;
  logic [RW-1:0]           row_cnt, row_nx;
  logic [SW-1:0]           s_cnt, s_nx;
  logic                    accept;
  logic [N*DATA_WIDTH-1:0] wbuf    [N];
  logic [N*DATA_WIDTH-1:0] wbuf_nx [N];
  logic [N*ACC_WIDTH-1:0]  psum_nx, psum_p1;
  logic [N-1:0]            cap_nx, cap_p1;
  logic                    ready_p1, busy_p1, done_p1, pass_p1;

  function automatic logic [ACC_WIDTH-1:0] zext(input logic [DATA_WIDTH-1:0] v);
    zext = {{(ACC_WIDTH-DATA_WIDTH){1'b0}}, v};
  endfunction

  assign accept = ready_p1 && w_valid;

  always_comb begin
    state_nx = state;
    row_nx   = row_cnt;
    s_nx     = s_cnt;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nx = FILL;
          row_nx   = '0;
        end
      end
      FILL: begin
        if (accept) begin
          row_nx = row_cnt + 1'b1;
          if (row_cnt == ROW_LAST) begin
            state_nx = STREAM;
            s_nx     = '0;
          end
        end
      end
      STREAM: begin
        s_nx = s_cnt + 1'b1;
        if (s_cnt == S_LAST) state_nx = DONE;
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Buffer view after this edge; lets the first stream cycle see the row arriving now.
  always_comb begin
    for (int r = 0; r < N; r++) begin
      wbuf_nx[r] = (accept && row_cnt == RW'(r)) ? w_data : wbuf[r];
    end
  end

  // Column c shows row r at s = c + (N-1-r): bottom row first, one cycle lag per column.
  always_comb begin
    psum_nx = '0;
    cap_nx  = '0;
    if (state_nx == STREAM) begin
      for (int c = 0; c < N; c++) begin
        for (int r = 0; r < N; r++) begin
          if (int'(s_nx) == N - 1 - r + c)
            psum_nx[c*ACC_WIDTH +: ACC_WIDTH] = zext(wbuf_nx[r][c*DATA_WIDTH +: DATA_WIDTH]);
        end
        cap_nx[c] = (int'(s_nx) == N - 1 + c);
      end
    end
  end

  // Stage p0 -> p1: control state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      row_cnt  <= '0;
      s_cnt    <= '0;
      ready_p1 <= 1'b0;
      busy_p1  <= 1'b0;
      done_p1  <= 1'b0;
      pass_p1  <= 1'b0;
      cap_p1   <= '0;
      psum_p1  <= '0;
    end else begin
      state    <= state_nx;
      row_cnt  <= row_nx;
      s_cnt    <= s_nx;
      ready_p1 <= (state_nx == FILL);
      busy_p1  <= (state_nx == FILL) || (state_nx == STREAM);
      done_p1  <= (state_nx == DONE);
      pass_p1  <= (state_nx == STREAM);
      cap_p1   <= cap_nx;
      psum_p1  <= psum_nx;
    end
  end

  always_ff @(posedge clk) begin
    wbuf <= wbuf_nx;
  end

  assign w_ready           = ready_p1;
  assign busy              = busy_p1;
  assign done              = done_p1;
  assign en_weight_pass    = pass_p1;
  assign en_weight_capture = cap_p1;
  assign psum_top          = psum_p1;

endmodule

// File: tb/tb_weight_loader.sv
// Directed bench for weight_loader (N=4): stream shape, skewed captures into a PE-chain
// model, backpressure, zero-extension, ignored inputs and mid-stream reset.
module tb_weight_loader;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int AW = 32;

  logic              clk = 1'b0;
  logic              rst, start, w_valid;
  logic [N*DW-1:0]   w_data;
  logic              w_ready, en_weight_pass, busy, done;
  logic [N*AW-1:0]   psum_top;
  logic [N-1:0]      en_weight_capture;

  weight_loader #(.N(N), .DATA_WIDTH(DW), .ACC_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .w_valid(w_valid), .w_data(w_data),
    .w_ready(w_ready), .psum_top(psum_top), .en_weight_pass(en_weight_pass),
    .en_weight_capture(en_weight_capture), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int scnt = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int start_cyc = 0;
  logic [N*AW-1:0] rec_psum [16];
  logic [N-1:0]    rec_cap  [16];
  logic [23:0]     upper_or = '0;
  logic [7:0]      wt [N][N];
  logic [AW-1:0]   pe_ps [N][N];
  logic [7:0]      pe_w  [N][N];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (en_weight_pass) begin
      if (scnt < 16) begin
        rec_psum[scnt] = psum_top;
        rec_cap[scnt]  = en_weight_capture;
      end
      scnt++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    for (int c = 0; c < N; c++) upper_or = upper_or | psum_top[c*AW+DW +: AW-DW];
  end

  // Column chains of PEs: psum moves down one row per pass cycle, capture per column.
  always @(posedge clk) begin : pe_model
    logic [AW-1:0] psin;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        psin = (r == 0) ? psum_top[c*AW +: AW] : pe_ps[r-1][c];
        if (en_weight_pass) pe_ps[r][c] <= psin;
        if (en_weight_capture[c]) pe_w[r][c] <= psin[7:0];
      end
    end
  end

  function automatic logic [N*DW-1:0] row_word(input int r);
    logic [N*DW-1:0] v;
    for (int c = 0; c < N; c++) v[c*DW +: DW] = wt[r][c];
    return v;
  endfunction

  task automatic begin_tile(input string tag, input int gap, input bit poke);
    bit acc;
    scnt = 0;
    start = 1'b1;
    start_cyc = cyc;
    tick();
    start = 1'b0;
    for (int r = 0; r < N; r++) begin
      w_valid = 1'b1;
      w_data  = row_word(r);
      if (poke && r == 2) start = 1'b1;
      acc = 1'b0;
      for (int k = 0; k < 20 && !acc; k++) begin
        @(negedge clk);
        acc = w_ready;
        @(posedge clk);
        #1;
      end
      if (!acc) chk({tag, "_row_timeout"}, 0, 1);
      w_valid = 1'b0;
      start   = 1'b0;
      repeat (gap) tick();
    end
  endtask

  task automatic load_tile(input string tag, input int gap, input bit poke);
    int d0;
    d0 = done_cnt;
    begin_tile(tag, gap, poke);
    if (poke) begin
      start = 1'b1;
      repeat (3) tick();
      start = 1'b0;
    end
    for (int k = 0; k < 60 && done_cnt == d0; k++) tick();
    chk({tag, "_done_seen"}, done_cnt - d0, 1);
  endtask

  task automatic check_stream(input string tag);
    logic [N*AW-1:0] ep;
    logic [N-1:0]    ec;
    chk({tag, "_len"}, scnt, 2*N-1);
    for (int s = 0; s < 2*N-1; s++) begin
      ep = '0;
      for (int c = 0; c < N; c++)
        if (s - c >= 0 && s - c <= N-1) ep[c*AW +: AW] = {24'h0, wt[N-1-(s-c)][c]};
      ec = (s >= N-1) ? 4'(1 << (s-(N-1))) : 4'b0;
      chk($sformatf("%s_psum_s%0d", tag, s), rec_psum[s], ep);
      chk($sformatf("%s_cap_s%0d", tag, s), rec_cap[s], ec);
    end
  endtask

  task automatic check_pes(input string tag);
    for (int r = 0; r < N; r++)
      chk($sformatf("%s_pe_row%0d", tag, r),
          {pe_w[r][3], pe_w[r][2], pe_w[r][1], pe_w[r][0]},
          {wt[r][3], wt[r][2], wt[r][1], wt[r][0]});
  endtask

  initial begin
    int d0;
    rst = 1'b1; start = 1'b0; w_valid = 1'b0; w_data = '0;
    repeat (3) tick();
    chk("reset_ctrl", {w_ready, busy, done, en_weight_pass, en_weight_capture}, 0);
    chk("reset_psum", psum_top, 0);
    rst = 1'b0;
    tick();

    // w_valid in IDLE is never accepted
    w_valid = 1'b1; w_data = 32'hDEADBEEF;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("idle_ready", {w_ready, busy}, 0);
    end
    w_valid = 1'b0;

    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) wt[r][c] = 8'(16*r + c + 1);

    load_tile("t1", 0, 1'b0);
    chk("t1_s0", rec_psum[0], 128'h31);
    chk("t1_s1", rec_psum[1], {64'h0, 32'h32, 32'h21});
    chk("t1_s6", rec_psum[6], {32'h04, 96'h0});
    chk("t1_caps", {rec_cap[3], rec_cap[4], rec_cap[5], rec_cap[6]}, 16'b0001_0010_0100_1000);
    chk("t1_latency", done_cyc - start_cyc, 12);
    check_stream("t1");
    check_pes("t1");
    tick();
    chk("t1_post", {w_ready, busy, done, en_weight_pass}, 0);

    load_tile("t3", 2, 1'b0);
    chk("t3_latency", done_cyc - start_cyc, 18);
    check_stream("t3");

    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) wt[r][c] = 8'hFF;
    upper_or = '0;
    load_tile("t4", 0, 1'b0);
    chk("t4_s3", rec_psum[3], {4{32'h000000FF}});
    check_stream("t4");
    chk("t4_upper", upper_or, 0);

    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) wt[r][c] = 8'(8'h50 + 4*r + c);
    d0 = done_cnt;
    load_tile("t5", 0, 1'b1);
    check_stream("t5");
    repeat (10) tick();
    chk("t5_one_done", done_cnt - d0, 1);
    chk("t5_idle", {busy, w_ready}, 0);

    begin_tile("t6", 0, 1'b0);
    repeat (4) tick();
    chk("t6_at_s4", {en_weight_pass, en_weight_capture}, 5'b1_0010);
    rst = 1'b1;
    tick();
    chk("t6_rst_ctrl", {w_ready, busy, done, en_weight_pass, en_weight_capture}, 0);
    chk("t6_rst_psum", psum_top, 0);
    rst = 1'b0;
    tick();
    chk("t6_stays_idle", {w_ready, busy, done, en_weight_pass}, 0);

    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) wt[r][c] = 8'(8'hA0 + 4*r + c);
    load_tile("t6b", 0, 1'b0);
    chk("t6b_latency", done_cyc - start_cyc, 12);
    check_stream("t6b");
    check_pes("t6b");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=finish", cyc);
    $fatal(1, "timeout");
  end

endmodule
